// File: rtl/alu_seq.sv
// Sequencer that drives an external 4-bit adder/ALU to run accumulator commands.
// Latency 1/2/3 cycles (LOAD,CLR,illegal / ADD,INC,DEC / SUB), ready only in IDLE.
module alu_seq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd,
    input  logic [3:0] operand,
    output logic       res_valid,
    output logic [3:0] acc,
    output logic       carry,
    output logic       zero,
    output logic       err,
    output logic       c1,
    output logic       c2,
    output logic [3:0] ia,
    output logic [3:0] ib,
    input  logic [3:0] sum,
    input  logic       cout
);

    typedef enum logic [1:0] {IDLE, EXEC1, EXEC2, DONE} state_t;

    localparam logic [2:0] CMD_LOAD = 3'b000;
    localparam logic [2:0] CMD_ADD  = 3'b001;
    localparam logic [2:0] CMD_SUB  = 3'b010;
    localparam logic [2:0] CMD_INC  = 3'b011;
    localparam logic [2:0] CMD_DEC  = 3'b100;
    localparam logic [2:0] CMD_CLR  = 3'b101;

    state_t     state;
    logic [2:0] cmd_q;
    logic [3:0] opnd_q;
    logic [1:0] op_sel;

    assign cmd_ready = (state == IDLE);
    assign ia        = opnd_q;
    assign ib        = acc;
    assign c1        = op_sel[1];
    assign c2        = op_sel[0];

    // SUB is ~operand + acc followed by an increment: acc + ~operand + 1.
    always_comb begin
        op_sel = 2'b00;
        if (state == EXEC1) begin
            case (cmd_q)
                CMD_SUB: op_sel = 2'b01;
                CMD_INC: op_sel = 2'b10;
                CMD_DEC: op_sel = 2'b11;
                default: op_sel = 2'b00;
            endcase
        end else if (state == EXEC2) begin
            op_sel = 2'b10;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cmd_q     <= 3'b000;
            opnd_q    <= 4'h0;
            acc       <= 4'h0;
            carry     <= 1'b0;
            zero      <= 1'b1;
            err       <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        cmd_q  <= cmd;
                        opnd_q <= operand;
                        err    <= 1'b0;
                        case (cmd)
                            CMD_LOAD: begin
                                acc       <= operand;
                                carry     <= 1'b0;
                                zero      <= (operand == 4'h0);
                                state     <= DONE;
                                res_valid <= 1'b1;
                            end
                            CMD_CLR: begin
                                acc       <= 4'h0;
                                carry     <= 1'b0;
                                zero      <= 1'b1;
                                state     <= DONE;
                                res_valid <= 1'b1;
                            end
                            CMD_ADD, CMD_SUB, CMD_INC, CMD_DEC: begin
                                state <= EXEC1;
                            end
                            default: begin
                                err       <= 1'b1;
                                state     <= DONE;
                                res_valid <= 1'b1;
                            end
                        endcase
                    end
                end
                EXEC1: begin
                    acc   <= sum;
                    carry <= cout;
                    zero  <= (sum == 4'h0);
                    if (cmd_q == CMD_SUB) begin
                        state <= EXEC2;
                    end else begin
                        state     <= DONE;
                        res_valid <= 1'b1;
                    end
                end
                EXEC2: begin
                    acc       <= sum;
                    carry     <= carry | cout;
                    zero      <= (sum == 4'h0);
                    state     <= DONE;
                    res_valid <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: behavioural adder, accumulator model and result scoreboard.
module tb_alu_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd;
    logic [3:0] operand;
    logic       res_valid;
    logic [3:0] acc;
    logic       carry;
    logic       zero;
    logic       err;
    logic       c1;
    logic       c2;
    logic [3:0] ia;
    logic [3:0] ib;
    logic [3:0] sum;
    logic       cout;

    typedef struct {
        logic [3:0] acc;
        logic       carry;
        logic       zero;
        logic       err;
        int         lat;
        logic [7:0] hist;
    } exp_t;

    exp_t       sb[$];
    int         total = 0;
    int         bad   = 0;
    logic [3:0] m_acc = 4'h0;
    logic       m_carry = 1'b0;

    alu_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd       (cmd),
        .operand   (operand),
        .res_valid (res_valid),
        .acc       (acc),
        .carry     (carry),
        .zero      (zero),
        .err       (err),
        .c1        (c1),
        .c2        (c2),
        .ia        (ia),
        .ib        (ib),
        .sum       (sum),
        .cout      (cout)
    );

    always #5 clk = ~clk;

    // The adder the sequencer talks to.
    always_comb begin
        case ({c1, c2})
            2'b00:   {cout, sum} = {1'b0, ia} + {1'b0, ib};
            2'b01:   {cout, sum} = {1'b0, ~ia} + {1'b0, ib};
            2'b10:   {cout, sum} = {1'b0, ib} + 5'd1;
            default: {cout, sum} = {1'b0, ib} + 5'd15;
        endcase
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected architectural result of one command, pushed to the scoreboard.
    task automatic model_push(input logic [2:0] c, input logic [3:0] op);
        exp_t e;
        e.err  = 1'b0;
        e.lat  = 2;
        e.hist = 8'h00;
        case (c)
            3'b000: begin m_acc = op; m_carry = 1'b0; e.lat = 1; end
            3'b001: {m_carry, m_acc} = {1'b0, m_acc} + {1'b0, op};
            3'b010: begin
                m_carry = (m_acc >= op);
                m_acc   = m_acc - op;
                e.lat   = 3;
                e.hist  = 8'h06;
            end
            3'b011: begin {m_carry, m_acc} = {1'b0, m_acc} + 5'd1; e.hist = 8'h02; end
            3'b100: begin m_carry = (m_acc != 4'h0); m_acc = m_acc - 4'h1; e.hist = 8'h03; end
            3'b101: begin m_acc = 4'h0; m_carry = 1'b0; e.lat = 1; end
            default: begin e.err = 1'b1; e.lat = 1; end
        endcase
        e.acc   = m_acc;
        e.carry = m_carry;
        e.zero  = (m_acc == 4'h0);
        sb.push_back(e);
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_ready"}, {7'b0, cmd_ready}, 8'h01);
    endtask

    task automatic check_result(input string tag, input int lat, input logic [7:0] hist);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 8'h01, 8'h00);
            return;
        end
        e = sb.pop_front();
        chk({tag, "_lat"},   8'(lat),          8'(e.lat));
        chk({tag, "_acc"},   {4'b0, acc},      {4'b0, e.acc});
        chk({tag, "_carry"}, {7'b0, carry},    {7'b0, e.carry});
        chk({tag, "_zero"},  {7'b0, zero},     {7'b0, e.zero});
        chk({tag, "_err"},   {7'b0, err},      {7'b0, e.err});
        chk({tag, "_ops"},   hist,             e.hist);
    endtask

    task automatic run(input string tag, input logic [2:0] c, input logic [3:0] op);
        int         lat = 0;
        logic [7:0] hist = 8'h00;
        logic [3:0] acc_at_res;
        model_push(c, op);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd       = c;
        operand   = op;
        wait_ready(tag);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        do begin
            @(negedge clk);
            lat++;
            if (!res_valid) hist = {hist[5:0], c1, c2};
        end while (!res_valid && lat < 20);
        check_result(tag, lat, hist);
        acc_at_res = acc;
        @(negedge clk);
        chk({tag, "_pulse"},  {7'b0, res_valid}, 8'h00);
        chk({tag, "_stable"}, {4'b0, acc},       {4'b0, acc_at_res});
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b1;
        cmd       = 3'b000;
        operand   = 4'h5;
        repeat (3) @(negedge clk);
        chk("rst_acc",   {4'b0, acc},         8'h00);
        chk("rst_carry", {7'b0, carry},       8'h00);
        chk("rst_zero",  {7'b0, zero},        8'h01);
        chk("rst_err",   {7'b0, err},         8'h00);
        chk("rst_res",   {7'b0, res_valid},   8'h00);
        chk("rst_ready", {7'b0, cmd_ready},   8'h01);
        chk("rst_sel",   {6'b0, c1, c2},      8'h00);
        chk("rst_ia_ib", {ia, ib},            8'h00);
        cmd_valid = 1'b0;
        rst_n     = 1'b1;
        @(negedge clk);
        chk("idle_res", {7'b0, res_valid}, 8'h00);

        run("load9",  3'b000, 4'd9);
        run("load12", 3'b000, 4'd12);
        run("add7",   3'b001, 4'd7);
        run("load5",  3'b000, 4'd5);
        run("sub3",   3'b010, 4'd3);
        run("load3",  3'b000, 4'd3);
        run("sub5",   3'b010, 4'd5);
        run("load0",  3'b000, 4'd0);
        run("sub0",   3'b010, 4'd0);
        run("load15", 3'b000, 4'd15);
        run("inc",    3'b011, 4'd0);
        run("dec",    3'b100, 4'd0);
        run("load15b", 3'b000, 4'd15);
        run("add1",   3'b001, 4'd1);
        run("load6",  3'b000, 4'd6);
        run("dec6",   3'b100, 4'd9);
        run("clr",    3'b101, 4'd3);

        // Illegal command with a second command queued behind it on a held valid.
        run("load10", 3'b000, 4'd10);
        model_push(3'b111, 4'd4);
        model_push(3'b000, 4'd6);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd       = 3'b111;
        operand   = 4'd4;
        wait_ready("ill");
        @(posedge clk);
        #1;
        cmd     = 3'b000;
        operand = 4'd6;
        @(negedge clk);
        chk("ill_res",     {7'b0, res_valid}, 8'h01);
        chk("ill_ready",   {7'b0, cmd_ready}, 8'h00);
        check_result("ill", 1, 8'h00);
        @(negedge clk);
        chk("ill_ready_back", {7'b0, cmd_ready}, 8'h01);
        chk("ill_res_low",    {7'b0, res_valid}, 8'h00);
        chk("ill_acc_kept",   {4'b0, acc},       8'h0a);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        chk("queued_res", {7'b0, res_valid}, 8'h01);
        check_result("queued", 1, 8'h00);

        // Reset while the second SUB pass is in progress.
        run("load7", 3'b000, 4'd7);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd       = 3'b010;
        operand   = 4'd2;
        wait_ready("rsub");
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        chk("rsub_exec1_sel", {6'b0, c1, c2}, 8'h01);
        @(negedge clk);
        chk("rsub_exec2_sel", {6'b0, c1, c2}, 8'h02);
        rst_n = 1'b0;
        #1;
        chk("rsub_res",   {7'b0, res_valid}, 8'h00);
        chk("rsub_acc",   {4'b0, acc},       8'h00);
        chk("rsub_zero",  {7'b0, zero},      8'h01);
        chk("rsub_carry", {7'b0, carry},     8'h00);
        chk("rsub_ready", {7'b0, cmd_ready}, 8'h01);
        m_acc   = 4'h0;
        m_carry = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("rsub_no_res", {7'b0, res_valid}, 8'h00);
        end
        rst_n = 1'b1;
        run("post_rst_inc", 3'b011, 4'd0);
        chk("sb_drained", 8'(sb.size()), 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
